// File: rtl/denise_bitplanes_gen.sv
// denise_bitplanes_gen: per-plane data buffers, parallel-load pixel shifters and per-playfield scroll delay lines.
// Latency: load one clk7 period after the BPL1DAT write; pixel bit to bpldata is 1 clk plus scr taps.
// No backpressure: a free-running video pipeline paced by clk7_en/c3; exhausted shifters emit blank pixels.
module denise_bitplanes_gen #(
  parameter int NPLANES = 8,
  parameter int MAXW    = 64,
  parameter int DLY_LEN = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk7_en,
  input  logic               c3,
  input  logic               aga,
  input  logic [8:1]         reg_address_in,
  input  logic [15:0]        data_in,
  input  logic [47:0]        chip48,
  input  logic               hires,
  input  logic               shres,
  input  logic [8:0]         hpos,
  input  logic [NPLANES-1:0] plane_en,
  output logic [NPLANES-1:0] bpldata,
  output logic               empty
);

  localparam int SW = $clog2(DLY_LEN);
  localparam logic [7:0] A_BPLCON1 = 8'h81;  // 0x102 >> 1
  localparam logic [7:0] A_FMODE   = 8'hFE;  // 0x1FC >> 1
  localparam logic [7:0] A_BPL1DAT = 8'h88;  // 0x110 >> 1

  logic [15:0]        bplcon1;
  logic [1:0]         fmode;
  logic [MAXW-1:0]    buffer  [NPLANES];
  logic [MAXW-1:0]    shifter [NPLANES];
  logic [6:0]         cnt     [NPLANES];
  logic [NPLANES-1:0] pix;
  logic               load;
  logic [7:0]         pf1h;
  logic [7:0]         pf2h;
  logic [8:0]         extra_r;
  logic [SW-1:0]      scr1;
  logic [SW-1:0]      scr2;
  logic [DLY_LEN-2:0] dly [NPLANES];

  logic [6:0]         fw;
  logic [63:0]        wide_word;
  logic               strobe;
  logic               do_load;
  logic [1:0]         phase;
  logic [1:0]         back;
  logic [8:0]         extra_next;
  logic [DLY_LEN-1:0] tap [NPLANES];
  logic               unused_bits;

  // Position-phase and truncation leftovers are intentionally ignored.
  assign unused_bits = ^{hpos[8:6], hpos[1:0], wide_word};

  // Scroll sum saturates at the last tap instead of wrapping.
  function automatic logic [SW-1:0] sat(input logic [7:0] h, input logic [8:0] e);
    logic [8:0] s;
    s = {1'b0, h} + e;
    if (s > 9'(DLY_LEN - 1)) sat = SW'(DLY_LEN - 1);
    else                     sat = s[SW-1:0];
  endfunction

  // Fetch width from FMODE, clamped to the shifter width.
  always_comb begin
    case (fmode)
      2'b00:   fw = 7'd16;
      2'b11:   fw = 7'd64;
      default: fw = 7'd32;
    endcase
    if (fw > 7'(MAXW)) fw = 7'(MAXW);
  end

  // Data word as seen by a buffer: bus word followed by the FMODE-selected chip48 slice.
  always_comb begin
    case (fmode)
      2'b00:   wide_word = {data_in, 48'h0};
      2'b11:   wide_word = {data_in, chip48};
      default: wide_word = {data_in, chip48[47:32], 32'h0};
    endcase
  end

  // Extra scroll compensating for where in the fetch slot the load landed.
  always_comb begin
    case (fw)
      7'd32:   phase = hpos[4:3];
      7'd64:   phase = hpos[5:4];
      default: phase = hpos[3:2];
    endcase
    back = 2'd0 - phase;
    case (fw)
      7'd32:   extra_next = {2'b00, back, 5'd0};
      7'd64:   extra_next = {1'b0, back, 6'd0};
      default: extra_next = {3'b000, back, 4'd0};
    endcase
  end

  // Pixel rate: shres every clk, hires twice per clk7, lores once per clk7.
  always_comb strobe = shres | (hires ? (clk7_en | c3) : clk7_en);

  assign do_load = clk7_en & load;
  assign empty   = (cnt[0] == 7'd0);

  // Register file: BPLCON1, FMODE, plane buffers and the load request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bplcon1 <= '0;
      fmode   <= '0;
      load    <= 1'b0;
      for (int i = 0; i < NPLANES; i++) buffer[i] <= '0;
    end else if (clk7_en) begin
      load <= (reg_address_in == A_BPL1DAT);
      if (reg_address_in == A_BPLCON1)
        bplcon1 <= aga ? data_in : {2'b00, 2'b11, 2'b00, 2'b11, data_in[7:0]};
      if (aga && (reg_address_in == A_FMODE))
        fmode <= data_in[1:0];
      for (int i = 0; i < NPLANES; i++)
        if (reg_address_in == (A_BPL1DAT + 8'(i)))
          buffer[i] <= wide_word[63 -: MAXW];
    end
  end

  // Shifters: parallel load wins over a coincident strobe; exhausted shifters emit blanks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix <= '0;
      for (int i = 0; i < NPLANES; i++) begin
        shifter[i] <= '0;
        cnt[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < NPLANES; i++) begin
        if (do_load) begin
          shifter[i] <= buffer[i];
          cnt[i]     <= fw;
        end else if (strobe) begin
          if (cnt[i] != 7'd0) begin
            pix[i]     <= shifter[i][MAXW-1];
            shifter[i] <= shifter[i] << 1;
            cnt[i]     <= cnt[i] - 7'd1;
          end else begin
            pix[i] <= 1'b0;
          end
        end
      end
    end
  end

  // Scroll snapshot at load; the tap select follows one clk7 period later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pf1h    <= '0;
      pf2h    <= '0;
      extra_r <= '0;
      scr1    <= '0;
      scr2    <= '0;
    end else if (clk7_en) begin
      if (load) begin
        pf1h    <= {bplcon1[11:10], bplcon1[3:0], bplcon1[9:8]};
        pf2h    <= {bplcon1[15:14], bplcon1[7:4], bplcon1[13:12]};
        extra_r <= extra_next;
      end
      scr1 <= sat(pf1h, extra_r);
      scr2 <= sat(pf2h, extra_r);
    end
  end

  // Tap 0 is the masked pixel itself, tap k is k clk older.
  always_comb begin
    for (int i = 0; i < NPLANES; i++) tap[i] = {dly[i], pix[i] & plane_en[i]};
  end

  // Delay lines shift every clk; odd planes follow playfield 1 scroll, even planes playfield 2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bpldata <= '0;
      for (int i = 0; i < NPLANES; i++) dly[i] <= '0;
    end else begin
      for (int i = 0; i < NPLANES; i++) begin
        dly[i]     <= tap[i][DLY_LEN-2:0];
        bpldata[i] <= tap[i][(i % 2 == 0) ? scr1 : scr2];
      end
    end
  end

endmodule

// File: tb/tb_denise_bitplanes_gen.sv
// tb_denise_bitplanes_gen: directed vectors for the bitplane serialiser.
// Pixel k of a lores load written at edge Ew appears on bpldata after edge Ew+9+4k+scr.
// Inputs change #1 after each rising edge; outputs are sampled at the same point.
module tb_denise_bitplanes_gen;

  localparam logic [7:0] A_BPLCON1 = 8'h81;
  localparam logic [7:0] A_FMODE   = 8'hFE;
  localparam logic [7:0] A_BPL1    = 8'h88;

  logic        clk;
  logic        reset;
  logic        clk7_en;
  logic        c3;
  logic        aga;
  logic [8:1]  reg_address_in;
  logic [15:0] data_in;
  logic [47:0] chip48;
  logic        hires;
  logic        shres;
  logic [8:0]  hpos;
  logic [7:0]  plane_en;
  logic [7:0]  bpldata;
  logic        empty;

  logic [1:0]  ph;
  int          n_chk;
  int          n_fail;
  logic [7:0]  cap [0:299];
  logic        emp [0:299];
  logic [7:0]  acc;
  logic        eacc;

  denise_bitplanes_gen #(.NPLANES(8), .MAXW(64), .DLY_LEN(256)) dut (
    .clk            (clk),
    .reset          (reset),
    .clk7_en        (clk7_en),
    .c3             (c3),
    .aga            (aga),
    .reg_address_in (reg_address_in),
    .data_in        (data_in),
    .chip48         (chip48),
    .hires          (hires),
    .shres          (shres),
    .hpos           (hpos),
    .plane_en       (plane_en),
    .bpldata        (bpldata),
    .empty          (empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clk; clk7_en/c3 describe the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    ph      = ph + 2'd1;
    clk7_en = (ph == 2'd0);
    c3      = (ph == 2'd2);
  endtask

  // Register write on the next clk7 edge; returns just after that edge.
  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    while (!clk7_en) step();
    reg_address_in = a;
    data_in        = d;
    step();
    reg_address_in = 8'h00;
  endtask

  // Record n samples after the last write edge, optionally injecting one write at edge wr_edge.
  task automatic capture(input int n, input int wr_edge, input logic [7:0] wa, input logic [15:0] wd);
    for (int k = 1; k <= n; k++) begin
      if (k == wr_edge) begin
        reg_address_in = wa;
        data_in        = wd;
      end else begin
        reg_address_in = 8'h00;
      end
      step();
      cap[k] = bpldata;
      emp[k] = empty;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) step();
    aga      = 1'b0;
    hires    = 1'b0;
    shres    = 1'b0;
    hpos     = 9'h000;
    plane_en = 8'hFF;
    chip48   = 48'h0;
    reset    = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    reset = 1'b1; clk7_en = 1'b0; c3 = 1'b0; ph = 2'd3;
    aga = 1'b0; reg_address_in = 8'h00; data_in = 16'h0; chip48 = 48'h0;
    hires = 1'b0; shres = 1'b0; hpos = 9'h000; plane_en = 8'hFF;
    repeat (3) step();
    check("rst_bpl", bpldata, 8'h00);
    check("rst_empty", empty, 1'b1);
    reset = 1'b0;

    // Idle after reset: nothing ever comes out.
    acc = 8'h00; eacc = 1'b1;
    repeat (1000) begin
      step();
      acc  = acc | bpldata;
      eacc = eacc & empty;
    end
    check("idle_bpl", acc, 8'h00);
    check("idle_empty", eacc, 1'b1);

    // Lores 16-bit fetch of 0x8001; FMODE write ignored without AGA.
    do_reset();
    chip48 = 48'hFFFF_0000_AAAA;
    wr(A_FMODE, 16'h0003);
    wr(A_BPL1, 16'h8001);
    capture(80, -1, 8'h00, 16'h0);
    check("lo_pre", cap[8][0], 1'b0);
    check("lo_p0_first", cap[9][0], 1'b1);
    check("lo_p0_last", cap[12][0], 1'b1);
    check("lo_p1", cap[13][0], 1'b0);
    check("lo_p14", cap[65][0], 1'b0);
    check("lo_p15", cap[69][0], 1'b1);
    check("lo_p15_last", cap[72][0], 1'b1);
    check("lo_blank", cap[73][0], 1'b0);
    check("lo_other_planes", cap[9][7:1], 7'h00);
    check("lo_emp_before_load", emp[3], 1'b1);
    check("lo_emp_at_load", emp[4], 1'b0);
    check("lo_emp_p15", emp[67], 1'b0);
    check("lo_emp_done", emp[68], 1'b1);

    // AGA 64-bit fetch: 0x0000 FFFF 0000 AAAA.
    do_reset();
    aga    = 1'b1;
    chip48 = 48'hFFFF_0000_AAAA;
    wr(A_FMODE, 16'h0003);
    wr(A_BPL1, 16'h0000);
    capture(280, -1, 8'h00, 16'h0);
    check("w64_p0", cap[9][0], 1'b0);
    check("w64_p15", cap[69][0], 1'b0);
    check("w64_p16", cap[73][0], 1'b1);
    check("w64_p31", cap[136][0], 1'b1);
    check("w64_p32", cap[137][0], 1'b0);
    check("w64_p47", cap[197][0], 1'b0);
    check("w64_p48", cap[201][0], 1'b1);
    check("w64_p49", cap[205][0], 1'b0);
    check("w64_p62", cap[257][0], 1'b1);
    check("w64_p63", cap[261][0], 1'b0);
    check("w64_emp_p63", emp[259], 1'b0);
    check("w64_emp_done", emp[260], 1'b1);

    // Non-AGA BPLCON1=0x0000 stores 0x3300: scroll 3.
    do_reset();
    wr(A_BPLCON1, 16'h0000);
    wr(A_BPL1, 16'h8000);
    capture(30, -1, 8'h00, 16'h0);
    check("sc0_before", cap[11][0], 1'b0);
    check("sc0_edge", cap[12][0], 1'b1);

    // Non-AGA BPLCON1=0x0011 stores 0x3311: scroll 7 on both playfields; a later rewrite is ignored.
    do_reset();
    wr(A_BPLCON1, 16'h0011);
    wr(A_BPL1 + 8'd1, 16'h8000);
    wr(A_BPL1, 16'h8001);
    capture(90, 20, A_BPLCON1, 16'h00FF);
    check("sc7_pf1_before", cap[15][0], 1'b0);
    check("sc7_pf1_edge", cap[16][0], 1'b1);
    check("sc7_pf2_before", cap[15][1], 1'b0);
    check("sc7_pf2_edge", cap[16][1], 1'b1);
    check("sc7_rewrite_before", cap[75][0], 1'b0);
    check("sc7_rewrite_edge", cap[76][0], 1'b1);

    // Saturation: pf1h=0xFF plus 192 extra clamps to tap 255.
    do_reset();
    aga  = 1'b1;
    hpos = 9'h010;
    wr(A_FMODE, 16'h0003);
    wr(A_BPLCON1, 16'h0F0F);
    wr(A_BPL1, 16'h8000);
    capture(275, -1, 8'h00, 16'h0);
    check("sat_no_wrap", cap[200][0], 1'b0);
    check("sat_before", cap[263][0], 1'b0);
    check("sat_first", cap[264][0], 1'b1);
    check("sat_last", cap[267][0], 1'b1);
    check("sat_after", cap[268][0], 1'b0);

    // Hires, all planes 0xFFFF, plane_en=0x55; load coincides with a hires strobe.
    do_reset();
    hires    = 1'b1;
    plane_en = 8'h55;
    for (int n = 2; n <= 8; n++) wr(A_BPL1 + 8'(n - 1), 16'hFFFF);
    wr(A_BPL1, 16'hFFFF);
    capture(45, -1, 8'h00, 16'h0);
    check("hi_before", cap[6], 8'h00);
    check("hi_first", cap[7], 8'h55);
    check("hi_last", cap[38], 8'h55);
    check("hi_blank", cap[39], 8'h00);
    check("hi_emp_p15", emp[35], 1'b0);
    check("hi_emp_done", emp[36], 1'b1);

    // Reset in the middle of a line clears the outputs immediately.
    do_reset();
    wr(A_BPL1, 16'hFFFF);
    capture(20, -1, 8'h00, 16'h0);
    check("mid_running", bpldata[0], 1'b1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_bpl", bpldata, 8'h00);
    check("mid_rst_empty", empty, 1'b1);
    repeat (2) step();
    reset = 1'b0;
    acc = 8'h00;
    repeat (100) begin
      step();
      acc = acc | bpldata;
    end
    check("post_rst_bpl", acc, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
